mux_n_rr: RTL and testbench

- Parametrised, registered N-channel multiplexer; successor to the combinational 4:1 mux.
- Selects one of CH input channels and delivers its data through a single-entry output register.
- Valid/ready handshake is used on every channel and on the output.
- Two grant modes: fixed select (driven by sel) or round-robin scan across channels that have data.
- Sits between multiple producer stages and one shared downstream consumer.

---
 rtl/mux_n_rr.sv | 97 +++++++++
 tb/tb_mux_n_rr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_n_rr.sv
// mux_n_rr: registered N-channel multiplexer with valid/ready handshake.
// Grants one channel per cycle. The grant comes from sel (mode=0) or from a
// round-robin scan starting at rr_ptr (mode=1). The granted word goes into a
// single-entry output register.
module mux_n_rr #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic [CH-1:0]         in_valid,
  output logic [CH-1:0]         in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_ch
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign can_load = !out_valid || out_ready;
  assign xfer     = grant_valid && can_load && rst_n;

  // Grant select: fixed index, or first valid channel at/after rr_ptr with wrap
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!mode) begin
      for (int unsigned c = 0; c < CH; c++) begin
        if (sel == SELW'(c) && in_valid[c]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(c);
        end
      end
    end else begin
      // First pass: channels rr_ptr..CH-1
      for (int unsigned c = 0; c < CH; c++) begin
        if (!grant_valid && in_valid[c] && (SELW'(c) >= rr_ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(c);
        end
      end
      // Wrapped pass: lowest valid channel below rr_ptr
      for (int unsigned c = 0; c < CH; c++) begin
        if (!grant_valid && in_valid[c]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(c);
        end
      end
    end
  end

  // Per-channel ready and data mux for the granted channel
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (grant_idx == SELW'(c)) begin
        grant_data  = in_data[c*WIDTH +: WIDTH];
        in_ready[c] = xfer;
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        if (mode) begin
          rr_ptr <= (grant_idx == LAST_CH) ? '0 : SELW'(grant_idx + 1'b1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed testbench for mux_n_rr (WIDTH=4, CH=4, SELW=2).
module tb_mux_n_rr;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  int n_cmp;
  int n_err;

  mux_n_rr #(.WIDTH(4), .CH(4), .SELW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; in_data = 16'h4321;
    mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %0h want 0", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0h want 0", out_ch); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL release_in_ready: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL release_valid: got %0h want 1", out_valid); end
    n_cmp++; if (out_data !== 4'h1) begin n_err++; $display("FAIL release_data: got %0h want 1", out_data); end
  endtask

  task automatic test_fixed();
    logic [3:0] d;
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 16'h4A21; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 4'hA) begin n_err++; $display("FAIL fixed_data: got %0h want a", out_data); end
    n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL fixed_ch: got %0h want 2", out_ch); end
    for (int k = 0; k < 3; k++) begin
      d = 4'(k + 11);
      in_data = {4'h4, d, 8'h21};
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== d) begin
        n_err++; $display("FAIL fixed_stream[%0d]: got v=%0h d=%0h want v=1 d=%0h", k, out_valid, out_data, d);
      end
    end
  endtask

  task automatic test_rr_fair();
    int unsigned exp_ch [6];
    logic [3:0]  e_rdy;
    exp_ch = '{0, 1, 2, 3, 0, 1};
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      e_rdy = 4'b0001 << exp_ch[i];
      n_cmp++; if (in_ready !== e_rdy) begin n_err++; $display("FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready, e_rdy); end
      tick();
      n_cmp++; if (out_ch !== 2'(exp_ch[i]) || out_data !== 4'(exp_ch[i] + 1)) begin
        n_err++; $display("FAIL rr_out[%0d]: got ch=%0d d=%0h want ch=%0d d=%0h", i, out_ch, out_data, exp_ch[i], exp_ch[i] + 1);
      end
    end
  endtask

  task automatic test_rr_skip();
    int unsigned exp_ch [4];
    logic [3:0]  e_rdy;
    exp_ch = '{3, 1, 3, 1};
    mode = 1'b1; in_valid = 4'b1010; in_data = 16'h4321; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e_rdy = 4'b0001 << exp_ch[i];
      n_cmp++; if (in_ready !== e_rdy) begin n_err++; $display("FAIL skip_in_ready[%0d]: got %b want %b", i, in_ready, e_rdy); end
      tick();
      n_cmp++; if (out_ch !== 2'(exp_ch[i]) || out_data !== 4'(exp_ch[i] + 1)) begin
        n_err++; $display("FAIL skip_out[%0d]: got ch=%0d d=%0h want ch=%0d d=%0h", i, out_ch, out_data, exp_ch[i], exp_ch[i] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 16'h0005; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 4'h5 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_load: got v=%0h d=%0h want v=1 d=5", out_valid, out_data); end
    out_ready = 1'b0; in_data = 16'h0007;
    for (int i = 0; i < 3; i++) begin
      sel = (i == 1) ? 2'd1 : 2'd0;
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
      tick();
      n_cmp++; if (out_data !== 4'h5 || out_valid !== 1'b1 || out_ch !== 2'd0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%0h d=%0h ch=%0d want v=1 d=5 ch=0", i, out_valid, out_data, out_ch);
      end
    end
    sel = 2'd0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release_ready: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_data !== 4'h7 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_release: got v=%0h d=%0h want v=1 d=7", out_valid, out_data); end
  endtask

  task automatic test_drain();
    in_valid = 4'b0000; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL drain_in_ready: got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h7 || out_ch !== 2'd0) begin n_err++; $display("FAIL drain_hold: got d=%0h ch=%0d want d=7 ch=0", out_data, out_ch); end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'h4321; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_ch !== 2'd2 || out_data !== 4'h3) begin n_err++; $display("FAIL ar_pre: got ch=%0d d=%0h want ch=2 d=3", out_ch, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0 || out_ch !== 2'd0) begin n_err++; $display("FAIL ar_regs: got d=%0h ch=%0d want d=0 ch=0", out_data, out_ch); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL ar_in_ready: got %b want 0000", in_ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b1; in_valid = 4'b1100;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL ar_first_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_ch !== 2'd2 || out_data !== 4'h3 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL ar_first_out: got v=%0h ch=%0d d=%0h want v=1 ch=2 d=3", out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_skip();
    test_backpressure();
    test_drain();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
